memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Two-requester controller that shares the single-ported data/instruction memory (combinational read, synchronous write, `response` handshake) between the instruction-fetch port (port 0, read-only) and the load/store port (port 1, read/write).
- Registers the winning request, drives one memory transaction, captures read data, and returns a one-cycle ack to the winner.
- Round-robin arbitration on conflict.
- Timeout counter guards against a memory that never asserts `response`.

Parameters:
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without `mem_response` before the transaction is aborted with error. Value 0 disables the timeout (wait forever).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  port 0 read request, held until i_ack
- i_address  in  32  port 0 byte address
- i_read_data  out  32  port 0 read data, valid when i_ack=1
- i_ack  out  1  port 0 completion pulse
- i_error  out  1  port 0 timeout flag, valid with i_ack
- d_read  in  1  port 1 read request, held until d_ack
- d_write  in  1  port 1 write request, held until d_ack
- d_address  in  32  port 1 byte address
- d_write_data  in  32  port 1 store data
- d_read_data  out  32  port 1 read data, valid when d_ack=1
- d_ack  out  1  port 1 completion pulse
- d_error  out  1  port 1 timeout flag, valid with d_ack
- mem_read  out  1  to memory `memory_read`
- mem_write  out  1  to memory `memory_write`
- mem_address  out  32  to memory `address`
- mem_write_data  out  32  to memory `write_data`
- mem_read_data  in  32  from memory `read_data`
- mem_response  in  1  from memory `response`

Behaviour:
- Clock and reset: single clock `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values:
  - State = IDLE; all ack/error outputs = 0.
  - mem_read, mem_write = 0; all data/address outputs = 0.
  - last_grant = 1, so port 0 wins the first conflict.
  - Timeout counter = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Port 0 requests when i_read=1; port 1 requests when d_read|d_write=1.
  - One requester: grant it.
  - Both requesting: grant the port opposite to last_grant.
  - On grant: latch port id, address, write data and op into registers. If d_read and d_write are both set, the op is a write. Update last_grant, clear the counter, go to ACCESS.
  - No request: stay in IDLE, memory strobes = 0.
- ACCESS:
  - Drive mem_read/mem_write, mem_address and mem_write_data from the latched registers. Inputs are not re-sampled.
  - mem_response=1: capture mem_read_data (0 for writes), clear error, go to RESP.
  - Else, if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1: read data = 0, set error, go to RESP.
  - Else increment the counter.
- RESP:
  - Memory strobes = 0.
  - Assert the granted port's ack for exactly one cycle, with its read_data and error registered.
  - The other port's ack stays 0.
  - Next state is IDLE.
  - Requester must drop or change its request in the cycle after ack. A still-asserted request in that IDLE is treated as a new transaction.
- Latency: with the memory answering in the first ACCESS cycle, request seen in IDLE at cycle N → mem strobe in N+1 → ack in N+2. Maximum throughput is 1 transaction per 3 cycles.
- Data outputs: i_read_data and d_read_data hold their last captured value between acks. Only the granted port's register is updated.
- Request dropped mid-transaction: the transaction still completes and the ack is still pulsed.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. Any in-flight write strobe is deasserted asynchronously, and a write that has not reached a clock edge is lost.
- mem_read and mem_write are never both 1, and are never asserted outside ACCESS.

Test Plan:
- Single read: preload mem[0x10]=0xDEADBEEF; i_read=1, i_address=0x40 → mem_read=1 one cycle later, i_ack=1 two cycles after request with i_read_data=0xDEADBEEF, i_error=0.
- Write then read: d_write=1, d_address=0x8, d_write_data=0x12345678 → d_ack pulse. Then d_read at 0x8 → d_read_data=0x12345678.
- Conflict round-robin: i_read and d_read held together from reset → grant order port0, port1, port0, port1. Each ack arrives 3 cycles apart and never simultaneously.
- Timeout: stub memory with mem_response=0, TIMEOUT_CYCLES=4; d_read → exactly 4 ACCESS cycles, then d_ack=1, d_error=1, d_read_data=0.
- Read+write both asserted on port 1 → only mem_write pulses, d_read_data=0.
- Reset mid-ACCESS: assert rst_n=0 while mem_write=1 → mem_write and all acks drop immediately. After release, the FSM is in IDLE and port 0 wins the first conflict.

Source files
------------

// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Shares one single-ported memory (combinational read, synchronous
//            write, response handshake) between an instruction-fetch port
//            (port 0, read-only) and a load/store port (port 1, read/write).
//            The winning request is registered, one memory transaction is
//            driven, read data is captured and a one-cycle ack is returned
//            to the winner. Conflicts are resolved round-robin. A timeout
//            counter aborts a transaction whose memory never responds.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            i_read/i_address    - port 0 read request (held until i_ack)
//            i_read_data/i_ack/i_error - port 0 completion (data/error valid
//                                  with i_ack)
//            d_read/d_write/d_address/d_write_data - port 1 request
//            d_read_data/d_ack/d_error - port 1 completion
//            mem_*               - memory-side strobes, address, data, response
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // port 0 : instruction fetch
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_read_data,
  output logic        i_ack,
  output logic        i_error,
  // port 1 : load/store
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_read_data,
  output logic        d_ack,
  output logic        d_error,
  // memory side
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_response
);

  localparam int c_cnt_w    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int c_last_int = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_last_int[c_cnt_w-1:0];
  localparam logic c_timeout_en = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_last_grant;  // 1 = port 1 won last time
  logic               r_port;        // port owning the current transaction
  logic               r_is_write;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_i_ack;
  logic               r_d_ack;
  logic               r_i_err;
  logic               r_d_err;
  logic [31:0]        r_i_rdata;
  logic [31:0]        r_d_rdata;

  logic        w_req0;
  logic        w_req1;
  logic        w_pick1;
  logic        w_grant_write;
  logic        w_timeout;
  logic [31:0] w_capture;

  assign w_req0 = i_read;
  assign w_req1 = d_read | d_write;
  // Port 1 wins when alone, or on a conflict when port 0 was served last.
  assign w_pick1 = w_req1 & (~w_req0 | ~r_last_grant);
  // A simultaneous read+write on port 1 is treated as a write.
  assign w_grant_write = w_pick1 & d_write;
  assign w_timeout = c_timeout_en & (r_cnt == c_cnt_last);
  // Writes and aborted transactions return zero read data.
  assign w_capture = (mem_response && !r_is_write) ? mem_read_data : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_port       <= 1'b0;
      r_is_write   <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_cnt        <= '0;
      r_i_ack      <= 1'b0;
      r_d_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_d_err      <= 1'b0;
      r_i_rdata    <= 32'd0;
      r_d_rdata    <= 32'd0;
    end else begin
      // acks are single-cycle pulses
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_port       <= w_pick1;
            r_last_grant <= w_pick1;
            r_is_write   <= w_grant_write;
            r_addr       <= w_pick1 ? d_address : i_address;
            r_wdata      <= w_pick1 ? d_write_data : 32'd0;
            // strobes are registered so they are high exactly in ACCESS
            r_mem_read   <= ~w_grant_write;
            r_mem_write  <= w_grant_write;
            r_cnt        <= '0;
            r_state      <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_response || w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_state     <= S_RESP;
            if (r_port) begin
              r_d_rdata <= w_capture;
              r_d_err   <= ~mem_response;
              r_d_ack   <= 1'b1;
            end else begin
              r_i_rdata <= w_capture;
              r_i_err   <= ~mem_response;
              r_i_ack   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_read_data    = r_i_rdata;
  assign i_ack          = r_i_ack;
  assign i_error        = r_i_err;
  assign d_read_data    = r_d_rdata;
  assign d_ack          = r_d_ack;
  assign d_error        = r_d_err;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;

endmodule
`default_nettype wire
